// File: rtl/hq_gram_calc.sv
`default_nettype none
// ============================================================================
// Module   : hq_gram_calc
// Brief    : 2x2 Hermitian Gram matrix G = Hq^H*Hq of a streamed 4x2 complex
//            Hq, tagged with the codeword index it was computed for.
// Revision : 1.0 - initial release
// ============================================================================
module hq_gram_calc #(
  parameter int Q         = 8,
  parameter int N         = 16,
  parameter int ACC_WIDTH = 36
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [3:0]                  q_index,
  input  logic                        hq_in_valid,
  input  logic signed [N-1:0]         hq_in_r,
  input  logic signed [N-1:0]         hq_in_i,
  output logic                        busy,
  output logic                        gram_valid,
  output logic signed [ACC_WIDTH-1:0] g00,
  output logic signed [ACC_WIDTH-1:0] g11,
  output logic signed [ACC_WIDTH-1:0] g01_r,
  output logic signed [ACC_WIDTH-1:0] g01_i,
  output logic [3:0]                  q_tag
);

  localparam int c_PW = 2*N + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCUM  = 2'd1,
    S_FLUSH  = 2'd2,
    S_OUTPUT = 2'd3
  } state_t;

  state_t                      r_state;
  logic [2:0]                  r_cnt;
  logic [3:0]                  r_qcap;
  logic signed [N-1:0]         r_ar, r_ai;
  logic signed [c_PW-1:0]      r_pn, r_pxr, r_pxi;
  logic                        r_pv, r_pj;
  logic signed [ACC_WIDTH-1:0] r_acc00, r_acc11, r_acc01r, r_acc01i;

  logic                        w_accept, w_start_acc;
  logic signed [c_PW-1:0]      w_xr, w_xi, w_ar, w_ai;
  logic signed [c_PW-1:0]      w_pn, w_pxr, w_pxi;
  logic signed [ACC_WIDTH-1:0] w_pn_ext, w_pxr_ext, w_pxi_ext;

  assign w_accept    = (r_state == S_ACCUM) && hq_in_valid;
  assign w_start_acc = (r_state == S_IDLE) && start;

  // Operands widened first so every product and sum is exact in c_PW bits.
  assign w_xr = {{(c_PW-N){hq_in_r[N-1]}}, hq_in_r};
  assign w_xi = {{(c_PW-N){hq_in_i[N-1]}}, hq_in_i};
  assign w_ar = {{(c_PW-N){r_ar[N-1]}}, r_ar};
  assign w_ai = {{(c_PW-N){r_ai[N-1]}}, r_ai};

  assign w_pn  = w_xr*w_xr + w_xi*w_xi;
  // conj(a)*b: real = ar*br + ai*bi, imag = ar*bi - ai*br
  assign w_pxr = w_ar*w_xr + w_ai*w_xi;
  assign w_pxi = w_ar*w_xi - w_ai*w_xr;

  assign w_pn_ext  = {{(ACC_WIDTH-c_PW){r_pn[c_PW-1]}},  r_pn};
  assign w_pxr_ext = {{(ACC_WIDTH-c_PW){r_pxr[c_PW-1]}}, r_pxr};
  assign w_pxi_ext = {{(ACC_WIDTH-c_PW){r_pxi[c_PW-1]}}, r_pxi};

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= 3'd0;
      r_qcap     <= 4'd0;
      busy       <= 1'b0;
      gram_valid <= 1'b0;
      g00        <= '0;
      g11        <= '0;
      g01_r      <= '0;
      g01_i      <= '0;
      q_tag      <= 4'd0;
    end else begin
      gram_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_qcap  <= q_index;
            r_cnt   <= 3'd0;
            busy    <= 1'b1;
            r_state <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (hq_in_valid) begin
            r_cnt <= r_cnt + 3'd1;
            if (r_cnt == 3'd7) r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          r_state <= S_OUTPUT;
        end
        S_OUTPUT: begin
          g00        <= r_acc00 >>> Q;
          g11        <= r_acc11 >>> Q;
          g01_r      <= r_acc01r >>> Q;
          g01_i      <= r_acc01i >>> Q;
          q_tag      <= r_qcap;
          gram_valid <= 1'b1;
          busy       <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Two-stage datapath: products registered on accept, accumulated one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ar     <= '0;
      r_ai     <= '0;
      r_pn     <= '0;
      r_pxr    <= '0;
      r_pxi    <= '0;
      r_pv     <= 1'b0;
      r_pj     <= 1'b0;
      r_acc00  <= '0;
      r_acc11  <= '0;
      r_acc01r <= '0;
      r_acc01i <= '0;
    end else if (w_start_acc) begin
      r_pv     <= 1'b0;
      r_acc00  <= '0;
      r_acc11  <= '0;
      r_acc01r <= '0;
      r_acc01i <= '0;
    end else begin
      r_pv <= w_accept;
      if (w_accept) begin
        r_pj <= r_cnt[0];
        r_pn <= w_pn;
        if (!r_cnt[0]) begin
          r_ar <= hq_in_r;
          r_ai <= hq_in_i;
        end else begin
          r_pxr <= w_pxr;
          r_pxi <= w_pxi;
        end
      end
      if (r_pv) begin
        if (!r_pj) begin
          r_acc00 <= r_acc00 + w_pn_ext;
        end else begin
          r_acc11  <= r_acc11 + w_pn_ext;
          r_acc01r <= r_acc01r + w_pxr_ext;
          r_acc01i <= r_acc01i + w_pxi_ext;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hq_gram_calc.sv
`default_nettype none
// ============================================================================
// Module   : tb_hq_gram_calc
// Brief    : Self-checking bench for hq_gram_calc (directed + random jobs).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hq_gram_calc;

  localparam int Q  = 8;
  localparam int N  = 16;
  localparam int AW = 36;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic [3:0]           q_index = 4'd0;
  logic                 hq_in_valid = 1'b0;
  logic signed [N-1:0]  hq_in_r = '0;
  logic signed [N-1:0]  hq_in_i = '0;
  logic                 busy, gram_valid;
  logic signed [AW-1:0] g00, g11, g01_r, g01_i;
  logic [3:0]           q_tag;

  int n_err = 0;
  int n_chk = 0;
  int er[8];
  int ei[8];

  hq_gram_calc #(.Q(Q), .N(N), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .q_index(q_index),
    .hq_in_valid(hq_in_valid), .hq_in_r(hq_in_r), .hq_in_i(hq_in_i),
    .busy(busy), .gram_valid(gram_valid),
    .g00(g00), .g11(g11), .g01_r(g01_r), .g01_i(g01_i), .q_tag(q_tag)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // G = Hq^H*Hq from row-major element lists: col0 = even, col1 = odd entries.
  function automatic void model(output longint e00, output longint e11,
                                output longint exr, output longint exi);
    longint s00 = 0, s11 = 0, sr = 0, si = 0;
    for (int i = 0; i < 4; i++) begin
      longint ar = er[2*i], ai = ei[2*i], br = er[2*i+1], bi = ei[2*i+1];
      s00 += ar*ar + ai*ai;
      s11 += br*br + bi*bi;
      sr  += ar*br + ai*bi;
      si  += ar*bi - ai*br;
    end
    e00 = s00 >>> Q; e11 = s11 >>> Q; exr = sr >>> Q; exi = si >>> Q;
  endfunction

  task automatic fill_const(input int ar, input int ai, input int br, input int bi);
    for (int i = 0; i < 4; i++) begin
      er[2*i] = ar; ei[2*i] = ai; er[2*i+1] = br; ei[2*i+1] = bi;
    end
  endtask

  task automatic fill_random();
    logic signed [N-1:0] t;
    for (int k = 0; k < 8; k++) begin
      t = 16'($urandom); er[k] = t;
      t = 16'($urandom); ei[k] = t;
    end
  endtask

  // Drives one job; returns negedges from the 8th accept to gram_valid seen.
  task automatic do_job(input logic [3:0] q, input int stall_max, input bit hold_start,
                        input bit skip_start, output int lat);
    if (!skip_start) begin
      start = 1'b1; q_index = q; hq_in_valid = 1'b1;
      hq_in_r = 16'($urandom); hq_in_i = 16'($urandom);
      @(negedge clk);
    end
    start = hold_start; q_index = ~q; hq_in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, stall_max)) begin
        hq_in_valid = 1'b0; hq_in_r = 16'($urandom); hq_in_i = 16'($urandom);
        @(negedge clk);
      end
      hq_in_valid = 1'b1; hq_in_r = 16'(er[k]); hq_in_i = 16'(ei[k]);
      start = hold_start | (k == 4);
      @(negedge clk);
      start = hold_start;
    end
    hq_in_valid = 1'b1; hq_in_r = 16'($urandom); hq_in_i = 16'($urandom);
    lat = 0;
    while (gram_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    hq_in_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    n_chk++; if (gram_valid !== 1'b0) begin n_err++; $display("FAIL rst_gv got=%0b exp=0", gram_valid); end
    n_chk++; if (g00 !== '0 || g11 !== '0) begin n_err++; $display("FAIL rst_diag got=%0d/%0d exp=0/0", g00, g11); end
    n_chk++; if (g01_r !== '0 || g01_i !== '0) begin n_err++; $display("FAIL rst_off got=%0d/%0d exp=0/0", g01_r, g01_i); end
    n_chk++; if (q_tag !== 4'd0) begin n_err++; $display("FAIL rst_qtag got=%0d exp=0", q_tag); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    int     lat;
    longint x00, x11, xr, xi;
    logic [3:0] q;
    for (int c = 0; c < 4; c++) begin
      case (c)
        0: begin fill_const(256, 0, 256, 0);             q = 4'd5;  x00 = 1024;     x11 = 1024;     xr = 1024;     xi = 0;     end
        1: begin fill_const(0, 256, 256, 0);             q = 4'd3;  x00 = 1024;     x11 = 1024;     xr = 0;        xi = -1024; end
        2: begin fill_const(-128, 0, 128, 128);          q = 4'd9;  x00 = 256;      x11 = 512;      xr = -256;     xi = -256;  end
        default: begin fill_const(-32768, -32768, -32768, -32768); q = 4'd12;
                 x00 = 33554432; x11 = 33554432; xr = 33554432; xi = 0; end
      endcase
      do_job(q, 0, 1'b0, 1'b0, lat);
      n_chk++; if (lat !== 2) begin n_err++; $display("FAIL dir%0d_latency got=%0d exp=2", c, lat); end
      n_chk++; if (g00 !== AW'(x00) || g11 !== AW'(x11)) begin n_err++;
        $display("FAIL dir%0d_diag got=%0d/%0d exp=%0d/%0d", c, g00, g11, x00, x11); end
      n_chk++; if (g01_r !== AW'(xr) || g01_i !== AW'(xi)) begin n_err++;
        $display("FAIL dir%0d_off got=%0d/%0d exp=%0d/%0d", c, g01_r, g01_i, xr, xi); end
      n_chk++; if (q_tag !== q || busy !== 1'b0) begin n_err++;
        $display("FAIL dir%0d_tag_busy got=%0d/%0b exp=%0d/0", c, q_tag, busy, q); end
      @(negedge clk);
      n_chk++; if (gram_valid !== 1'b0 || g00 !== AW'(x00)) begin n_err++;
        $display("FAIL dir%0d_pulse_hold got gv=%0b g00=%0d exp gv=0 g00=%0d", c, gram_valid, g00, x00); end
    end
  endtask

  task automatic test_stall();
    int lat;
    fill_const(256, 0, 256, 0);
    do_job(4'd5, 3, 1'b0, 1'b0, lat);
    n_chk++; if (lat !== 2) begin n_err++; $display("FAIL stall_latency got=%0d exp=2", lat); end
    n_chk++; if (g00 !== AW'(1024) || g11 !== AW'(1024) || g01_r !== AW'(1024) || g01_i !== '0) begin n_err++;
      $display("FAIL stall_vals got=%0d/%0d/%0d/%0d exp=1024/1024/1024/0", g00, g11, g01_r, g01_i); end
    n_chk++; if (q_tag !== 4'd5) begin n_err++; $display("FAIL stall_qtag got=%0d exp=5", q_tag); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int     lat;
    longint x00, x11, xr, xi;
    logic [3:0] q;
    for (int it = 0; it < 8; it++) begin
      fill_random();
      q = 4'($urandom);
      model(x00, x11, xr, xi);
      do_job(q, 2, 1'b0, 1'b0, lat);
      n_chk++; if (lat !== 2) begin n_err++; $display("FAIL rnd%0d_latency got=%0d exp=2", it, lat); end
      n_chk++; if (g00 !== AW'(x00) || g11 !== AW'(x11)) begin n_err++;
        $display("FAIL rnd%0d_diag got=%0d/%0d exp=%0d/%0d", it, g00, g11, x00, x11); end
      n_chk++; if (g01_r !== AW'(xr) || g01_i !== AW'(xi)) begin n_err++;
        $display("FAIL rnd%0d_off got=%0d/%0d exp=%0d/%0d", it, g01_r, g01_i, xr, xi); end
      n_chk++; if (q_tag !== q) begin n_err++; $display("FAIL rnd%0d_qtag got=%0d exp=%0d", it, q_tag, q); end
      @(negedge clk);
    end
  endtask

  task automatic test_rst_midjob();
    int lat;
    int seen;
    fill_const(256, 0, 256, 0);
    start = 1'b1; q_index = 4'd7; hq_in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      hq_in_valid = 1'b1; hq_in_r = 16'(er[k]); hq_in_i = 16'(ei[k]);
      @(negedge clk);
    end
    hq_in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    n_chk++; if (busy !== 1'b0 || gram_valid !== 1'b0) begin n_err++;
      $display("FAIL midrst_flags got busy=%0b gv=%0b exp 0/0", busy, gram_valid); end
    n_chk++; if (g00 !== '0 || q_tag !== 4'd0) begin n_err++;
      $display("FAIL midrst_outs got g00=%0d tag=%0d exp 0/0", g00, q_tag); end
    rst = 1'b0;
    seen = 0;
    repeat (6) begin
      hq_in_valid = 1'b1; hq_in_r = 16'($urandom); hq_in_i = 16'($urandom);
      @(negedge clk);
      if (gram_valid === 1'b1) seen++;
    end
    n_chk++; if (seen !== 0 || busy !== 1'b0) begin n_err++;
      $display("FAIL midrst_idle got pulses=%0d busy=%0b exp 0/0", seen, busy); end
    hq_in_valid = 1'b0;
    do_job(4'd5, 1, 1'b0, 1'b0, lat);
    n_chk++; if (lat !== 2) begin n_err++; $display("FAIL midrst_latency got=%0d exp=2", lat); end
    n_chk++; if (g00 !== AW'(1024) || g11 !== AW'(1024) || g01_r !== AW'(1024) || g01_i !== '0) begin n_err++;
      $display("FAIL midrst_vals got=%0d/%0d/%0d/%0d exp=1024/1024/1024/0", g00, g11, g01_r, g01_i); end
    n_chk++; if (q_tag !== 4'd5) begin n_err++; $display("FAIL midrst_qtag got=%0d exp=5", q_tag); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int     lat;
    longint x00, x11, xr, xi;
    fill_random();
    model(x00, x11, xr, xi);
    do_job(4'd2, 1, 1'b1, 1'b0, lat);
    n_chk++; if (lat !== 2 || q_tag !== 4'd2) begin n_err++;
      $display("FAIL b2b1_lat_tag got=%0d/%0d exp=2/2", lat, q_tag); end
    n_chk++; if (g00 !== AW'(x00) || g01_i !== AW'(xi)) begin n_err++;
      $display("FAIL b2b1_vals got=%0d/%0d exp=%0d/%0d", g00, g01_i, x00, xi); end
    q_index = 4'd11;
    @(negedge clk);
    n_chk++; if (busy !== 1'b1 || gram_valid !== 1'b0) begin n_err++;
      $display("FAIL b2b_rearm got busy=%0b gv=%0b exp 1/0", busy, gram_valid); end
    fill_random();
    model(x00, x11, xr, xi);
    do_job(4'd11, 1, 1'b0, 1'b1, lat);
    n_chk++; if (lat !== 2 || q_tag !== 4'd11) begin n_err++;
      $display("FAIL b2b2_lat_tag got=%0d/%0d exp=2/11", lat, q_tag); end
    n_chk++; if (g00 !== AW'(x00) || g11 !== AW'(x11) || g01_r !== AW'(xr) || g01_i !== AW'(xi)) begin n_err++;
      $display("FAIL b2b2_vals got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d",
               g00, g11, g01_r, g01_i, x00, x11, xr, xi); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_rst_midjob();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
